// File: rtl/layer_result_uart_tx.sv
// Captures the layer output pixel stream into a buffer, then sends it to the host
// as one UART 8N1 frame: sync byte, the captured bytes, mod-256 checksum.
module layer_result_uart_tx #(
  parameter int          DEPTH        = 196,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid_in,
  input  logic [7:0] pixel_in,
  input  logic       layer_done,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [PW-1:0] FULL     = PW'(DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    STOP_IDX = 4'd9;
  localparam logic [3:0]    LAST_DAT = 4'd8;

  localparam logic [2:0] CAPTURE = 3'd0;
  localparam logic [2:0] TX_SYNC = 3'd1;
  localparam logic [2:0] TX_DATA = 3'd2;
  localparam logic [2:0] TX_SUM  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    checksum;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          primed;
  logic [7:0]    rd_data;
  logic [7:0]    mem [DEPTH];

  logic capture_en;
  assign capture_en = (state == CAPTURE) && data_valid_in && (wr_ptr != FULL);

  // NOTE: the buffer has no reset so it maps onto block RAM; every byte read is written first.
  always_ff @(posedge clk) begin
    if (capture_en) mem[wr_ptr[AW-1:0]] <= pixel_in;
    rd_data <= mem[rd_ptr[AW-1:0]];
  end

  // rd_ptr always points at the next byte to load, so rd_data is prefetched a full
  // byte time before it is needed and consecutive bytes leave the line with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CAPTURE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      checksum <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      primed   <= 1'b0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (data_valid_in && !capture_en) overflow <= 1'b1;

      case (state)
        CAPTURE: begin
          if (capture_en) begin
            wr_ptr   <= wr_ptr + PW'(1);
            checksum <= checksum + pixel_in;
          end
          if (layer_done) begin
            // Pretend a stop bit is just ending so the next edge opens the sync byte.
            state    <= TX_SYNC;
            busy     <= 1'b1;
            baud_cnt <= BAUD_MAX;
            bit_idx  <= STOP_IDX;
            primed   <= 1'b0;
            rd_ptr   <= '0;
          end
        end

        TX_SYNC, TX_DATA, TX_SUM: begin
          if (baud_cnt != BAUD_MAX) begin
            baud_cnt <= baud_cnt + BW'(1);
          end else begin
            baud_cnt <= '0;
            if (bit_idx != STOP_IDX) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == LAST_DAT) begin
                uart_tx <= 1'b1;
              end else begin
                uart_tx <= shreg[0];
                shreg   <= shreg >> 1;
              end
            end else begin
              bit_idx <= '0;
              if (state == TX_SUM) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                uart_tx <= 1'b0;
                if (state == TX_SYNC && !primed) begin
                  shreg  <= SYNC_BYTE;
                  primed <= 1'b1;
                end else if (rd_ptr != wr_ptr) begin
                  state  <= TX_DATA;
                  shreg  <= rd_data;
                  rd_ptr <= rd_ptr + PW'(1);
                end else begin
                  state <= TX_SUM;
                  shreg <= checksum;
                end
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_result_uart_tx.sv
// Self-checking bench: drives pixel streams, decodes the serial line with a mid-bit
// sampling receiver and compares against a frame built from captured pixels.
module tb_layer_result_uart_tx;

  localparam int DEPTH    = 196;
  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid_in = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic       layer_done = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic       done;
  logic       overflow;

  layer_result_uart_tx #(
    .DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_valid_in(data_valid_in),
    .pixel_in(pixel_in),
    .layer_done(layer_done),
    .uart_tx(uart_tx),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_q[$];
  bit         exp_ovf;
  bit         in_capture;
  logic [7:0] rx_q[$];
  logic [7:0] t1_q[$];
  bit         line_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pixel(input logic [7:0] v);
    if (!in_capture || cap_q.size() >= DEPTH) exp_ovf = 1'b1;
    else cap_q.push_back(v);
  endtask

  task automatic send_pixel(input logic [7:0] v, input int gap);
    data_valid_in = 1'b1;
    pixel_in      = v;
    model_pixel(v);
    tick();
    data_valid_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    data_valid_in = 1'b0;
    layer_done    = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    cap_q.delete();
    exp_ovf    = 1'b0;
    in_capture = 1'b1;
  endtask

  // Issues layer_done (optionally with a coincident pixel), records the line until done,
  // then decodes and compares it with the frame expected from the captured pixels.
  task automatic run_frame(input string name, input bit with_pix, input logic [7:0] v);
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int sum, done_at, busy_low, n_err, n_frm, nbytes, base;
    if (with_pix) begin
      data_valid_in = 1'b1;
      pixel_in      = v;
      model_pixel(v);
    end
    layer_done = 1'b1;
    tick();
    layer_done    = 1'b0;
    data_valid_in = 1'b0;
    in_capture    = 1'b0;

    sum = 0;
    exp_q.push_back(8'hA5);
    foreach (cap_q[i]) begin
      exp_q.push_back(cap_q[i]);
      sum += int'(cap_q[i]);
    end
    exp_q.push_back(8'(sum % 256));

    check({name, ".idle_before_start"}, uart_tx, 1);
    check({name, ".busy_at_start"}, busy, 1);

    line_q.delete();
    done_at  = -1;
    busy_low = 0;
    for (int c = 1; c <= exp_q.size() * BYTE_CYC + 50; c++) begin
      tick();
      if (done) begin
        done_at = c;
        break;
      end
      line_q.push_back(uart_tx);
      if (!busy) busy_low++;
    end

    check({name, ".done_cycle"}, done_at, exp_q.size() * BYTE_CYC + 1);
    check({name, ".busy_gaps"}, busy_low, 0);
    check({name, ".busy_after_done"}, busy, 0);
    check({name, ".start_edge"}, (line_q.size() > 0) ? 32'(line_q[0]) : 32'd1, 0);

    rx_q.delete();
    n_frm  = 0;
    nbytes = line_q.size() / BYTE_CYC;
    for (int k = 0; k < nbytes; k++) begin
      base = k * BYTE_CYC + CPB / 2;
      if (line_q[base] != 1'b0 || line_q[base + 9 * CPB] != 1'b1) n_frm++;
      for (int i = 0; i < 8; i++) b[i] = line_q[base + (i + 1) * CPB];
      rx_q.push_back(b);
    end
    n_err = 0;
    foreach (rx_q[k]) begin
      if (k < exp_q.size() && rx_q[k] !== exp_q[k]) begin
        if (n_err == 0) $display("%s: first byte difference at %0d: 0x%0h vs 0x%0h", name, k, rx_q[k], exp_q[k]);
        n_err++;
      end
    end
    check({name, ".byte_count"}, nbytes, exp_q.size());
    check({name, ".byte_diffs"}, n_err, 0);
    check({name, ".framing_errors"}, n_frm, 0);
    check({name, ".overflow"}, overflow, exp_ovf);
  endtask

  initial begin
    int n, gap, diffs, bad_line;
    bit wp;

    // Reset state
    do_reset();
    check("reset.uart_tx", uart_tx, 1);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.overflow", overflow, 0);

    // T1 full map
    for (int k = 0; k < DEPTH; k++) send_pixel(8'(k), 0);
    run_frame("t1", 1'b0, 8'h00);
    check("t1.checksum", (rx_q.size() > 0) ? 32'(rx_q[rx_q.size() - 1]) : 32'hFFFF, 8'hA6);
    t1_q = rx_q;

    // T5 reset during data byte 50, while data bit 0 (a zero) is on the line
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_pixel(8'(k), 0);
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    repeat (51 * BYTE_CYC + CPB + 2) tick();
    check("t5.line_before_reset", uart_tx, 0);
    check("t5.busy_before_reset", busy, 1);
    rst = 1'b1;
    tick();
    check("t5.uart_tx_after_reset", uart_tx, 1);
    check("t5.busy_after_reset", busy, 0);
    check("t5.done_after_reset", done, 0);
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_pixel(8'(k), 0);
    run_frame("t5", 1'b0, 8'h00);
    diffs = (rx_q.size() == t1_q.size()) ? 0 : 1;
    foreach (rx_q[k]) if (k < t1_q.size() && rx_q[k] !== t1_q[k]) diffs++;
    check("t5.same_as_t1", diffs, 0);

    // T3 overflow
    do_reset();
    for (int k = 0; k < 200; k++) send_pixel(8'(k), 0);
    run_frame("t3", 1'b0, 8'h00);
    check("t3.checksum", (rx_q.size() > 0) ? 32'(rx_q[rx_q.size() - 1]) : 32'hFFFF, 8'hA6);
    check("t3.overflow_set", overflow, 1);

    // T4 empty
    do_reset();
    run_frame("t4", 1'b0, 8'h00);

    // Randomized frames, sometimes with a pixel coincident with layer_done
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        gap = $urandom_range(0, 3);
        send_pixel(8'($urandom), gap);
      end
      wp = 1'($urandom_range(0, 1));
      run_frame("rnd", wp, 8'($urandom));
    end

    // T2 gapped input
    do_reset();
    send_pixel(8'h7F, 2);
    send_pixel(8'h80, 2);
    send_pixel(8'hFF, 2);
    send_pixel(8'h01, 2);
    run_frame("t2", 1'b0, 8'h00);
    check("t2.checksum", (rx_q.size() > 0) ? 32'(rx_q[rx_q.size() - 1]) : 32'hFFFF, 8'hFF);
    check("t2.no_overflow", overflow, 0);

    // T6 activity after done
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    for (int i = 0; i < 3; i++) send_pixel(8'(i + 1), 0);
    bad_line = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (uart_tx !== 1'b1 || done !== 1'b1 || busy !== 1'b0) bad_line++;
    end
    check("t6.line_quiet_done_held", bad_line, 0);
    check("t6.overflow", overflow, exp_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
